// File: rtl/spi_xfer_queue.sv
// spi_xfer_queue: byte queue front end for the spi_norm SPI master.
//   The host pushes bytes into a TX FIFO. A sequencer hands each byte to
//   spi_norm using the load/busy handshake and stores the reply byte in an RX
//   FIFO, which the host reads back (first-word fall-through).
// Ports:
//   clk, rst            system clock; asynchronous active-low reset
//   tx_wr, tx_data      host push into the TX FIFO; tx_full reports a full FIFO
//   rx_rd, rx_data      host pop from the RX FIFO; rx_data is the head, 0 when empty
//   rx_empty            RX FIFO holds no entries
//   rx_ovf, start_err   sticky error flags, cleared by err_clr
//   spi_data, spi_load  byte and load strobe to spi_norm
//   spi_busy            busy from spi_norm
//   spi_rx_data         received byte from spi_norm
//   active              sequencer not idle, or TX FIFO not empty
//
// state     | meaning
// IDLE      | waiting for a TX byte while spi_norm is not busy
// LOAD      | spi_load high, waiting for spi_busy to rise (with timeout)
// WAIT_DONE | transfer running, waiting for spi_busy to fall
// CAPTURE   | store spi_rx_data into the RX FIFO
module spi_xfer_queue #(
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int START_TO = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_wr,
  input  logic [7:0] tx_data,
  output logic       tx_full,
  input  logic       rx_rd,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_ovf,
  output logic       start_err,
  input  logic       err_clr,
  output logic [7:0] spi_data,
  output logic       spi_load,
  input  logic       spi_busy,
  input  logic [7:0] spi_rx_data,
  output logic       active
);

  localparam int TW = $clog2(START_TO + 1);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, CAPTURE} state_t;

  state_t      state_q, state_d;
  logic [AW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [7:0]  spi_data_q, spi_data_d;
  logic        spi_load_q, spi_load_d;
  logic        rx_ovf_q, rx_ovf_d;
  logic        start_err_q, start_err_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]  tx_mem_q [DEPTH];
  logic [7:0]  rx_mem_q [DEPTH];

  logic tx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic ovf_set, to_set;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = ((tx_wp_q ^ tx_rp_q) == FULL_XOR);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = ((rx_wp_q ^ rx_rp_q) == FULL_XOR);
  assign tx_push  = tx_wr & ~tx_full;
  assign rx_pop   = rx_rd & ~rx_empty;

  always_comb begin
    state_d    = state_q;
    spi_data_d = spi_data_q;
    spi_load_d = spi_load_q;
    tmr_d      = tmr_q;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    ovf_set    = 1'b0;
    to_set     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_empty && !spi_busy) begin
          spi_data_d = tx_mem_q[tx_rp_q[AW-1:0]];
          tx_pop     = 1'b1;
          spi_load_d = 1'b1;
          tmr_d      = TW'(START_TO - 1);
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (spi_busy) begin
          spi_load_d = 1'b0;
          state_d    = WAIT_DONE;
        end else if (tmr_q == '0) begin
          // spi_norm never acknowledged: drop the byte, no RX entry
          spi_load_d = 1'b0;
          to_set     = 1'b1;
          state_d    = IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!spi_busy) state_d = CAPTURE;
      end
      CAPTURE: begin
        // full is judged before any same-cycle host pop
        if (rx_full) ovf_set = 1'b1;
        else         rx_push = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_wp_d     = tx_push ? tx_wp_q + PTR_ONE : tx_wp_q;
  assign tx_rp_d     = tx_pop  ? tx_rp_q + PTR_ONE : tx_rp_q;
  assign rx_wp_d     = rx_push ? rx_wp_q + PTR_ONE : rx_wp_q;
  assign rx_rp_d     = rx_pop  ? rx_rp_q + PTR_ONE : rx_rp_q;
  // a new error in the same cycle as err_clr keeps the flag set
  assign rx_ovf_d    = (rx_ovf_q & ~err_clr) | ovf_set;
  assign start_err_d = (start_err_q & ~err_clr) | to_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tx_wp_q     <= '0;
      tx_rp_q     <= '0;
      rx_wp_q     <= '0;
      rx_rp_q     <= '0;
      spi_data_q  <= '0;
      spi_load_q  <= 1'b0;
      rx_ovf_q    <= 1'b0;
      start_err_q <= 1'b0;
      tmr_q       <= '0;
    end else begin
      state_q     <= state_d;
      tx_wp_q     <= tx_wp_d;
      tx_rp_q     <= tx_rp_d;
      rx_wp_q     <= rx_wp_d;
      rx_rp_q     <= rx_rp_d;
      spi_data_q  <= spi_data_d;
      spi_load_q  <= spi_load_d;
      rx_ovf_q    <= rx_ovf_d;
      start_err_q <= start_err_d;
      tmr_q       <= tmr_d;
    end
  end

  // storage needs no reset: pointers define which entries are valid
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q[AW-1:0]] <= tx_data;
    if (rx_push) rx_mem_q[rx_wp_q[AW-1:0]] <= spi_rx_data;
  end

  assign rx_data   = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q[AW-1:0]];
  assign spi_data  = spi_data_q;
  assign spi_load  = spi_load_q;
  assign rx_ovf    = rx_ovf_q;
  assign start_err = start_err_q;
  assign active    = (state_q != IDLE) | ~tx_empty;

endmodule

// File: tb/tb_spi_xfer_queue.sv
module tb_spi_xfer_queue;
  localparam int DEPTH = 8;

  logic       clk, rst, tx_wr, rx_rd, err_clr;
  logic [7:0] tx_data, spi_rx_data;
  logic       slave_busy, stall, mute;
  logic       spi_busy;
  logic       tx_full, rx_empty, rx_ovf, start_err, spi_load, active;
  logic [7:0] rx_data, spi_data;

  assign spi_busy = slave_busy | stall;

  spi_xfer_queue dut (
    .clk(clk), .rst(rst), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .rx_ovf(rx_ovf),
    .start_err(start_err), .err_clr(err_clr), .spi_data(spi_data),
    .spi_load(spi_load), .spi_busy(spi_busy), .spi_rx_data(spi_rx_data),
    .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int xfers    = 0;

  // reference model: bytes awaiting transfer, replies awaiting readback
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] reply_q[$];
  logic       exp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // spi_norm behavioural model: on each new load, check the byte, then
  // raise busy after a random delay, hold it, and return a reply byte
  logic load_prev = 1'b0;
  initial begin
    slave_busy  = 1'b0;
    spi_rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst && spi_load && !load_prev) begin
        xfers++;
        chk("load_while_busy", {31'd0, spi_busy}, 32'd0);
        if (exp_tx.size() == 0) begin
          n_checks++;
          n_err++;
          $error("FAIL spi_data: unexpected load with data %0h, none queued", spi_data);
        end else begin
          chk("spi_data", {24'd0, spi_data}, {24'd0, exp_tx.pop_front()});
        end
        if (!mute) begin
          logic [7:0] rep;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          slave_busy = 1'b1;
          repeat ($urandom_range(1, 4)) @(negedge clk);
          rep = (reply_q.size() > 0) ? reply_q.pop_front() : 8'($urandom);
          spi_rx_data = rep;
          slave_busy  = 1'b0;
          if (exp_rx.size() < DEPTH) exp_rx.push_back(rep);
          else exp_ovf = 1'b1;
        end
      end
      load_prev = spi_load;
    end
  end

  task automatic push1(input logic [7:0] b);
    @(negedge clk);
    tx_wr = 1'b1;
    tx_data = b;
    if (exp_tx.size() < DEPTH) exp_tx.push_back(b);
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((active || spi_busy || spi_load) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      n_checks++;
      n_err++;
      $error("FAIL idle_timeout: active=%0b busy=%0b load=%0b after %0d cycles", active, spi_busy, spi_load, k);
    end
    @(negedge clk);
  endtask

  task automatic wait_load();
    int k = 0;
    while (!spi_load && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      n_checks++;
      n_err++;
      $error("FAIL load_timeout: spi_load stayed %0b for %0d cycles", spi_load, k);
    end
  endtask

  task automatic drain();
    while (exp_rx.size() > 0) begin
      chk("rx_empty_drain", {31'd0, rx_empty}, 32'd0);
      chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
    end
    chk("rx_empty_after_drain", {31'd0, rx_empty}, 32'd1);
    chk("rx_data_empty", {24'd0, rx_data}, 32'd0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    int base, cnt, n;
    rst = 1'b0; tx_wr = 1'b0; tx_data = 8'h00; rx_rd = 1'b0; err_clr = 1'b0;
    stall = 1'b0; mute = 1'b0;
    #12;
    chk("rst_tx_full", {31'd0, tx_full}, 32'd0);
    chk("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
    chk("rst_spi_load", {31'd0, spi_load}, 32'd0);
    chk("rst_spi_data", {24'd0, spi_data}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // reset while spi_load is high
    mute = 1'b1;
    push1(8'h3C);
    wait_load();
    rst = 1'b0;
    #1;
    chk("rst_mid_load", {31'd0, spi_load}, 32'd0);
    chk("rst_mid_rx_empty", {31'd0, rx_empty}, 32'd1);
    chk("rst_mid_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_mid_spi_data", {24'd0, spi_data}, 32'd0);
    chk("rst_mid_start_err", {31'd0, start_err}, 32'd0);
    chk("rst_mid_active", {31'd0, active}, 32'd0);
    exp_tx.delete();
    mute = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // single transfer with load latency
    reply_q.push_back(8'hA5);
    @(negedge clk);
    tx_wr = 1'b1; tx_data = 8'd31; exp_tx.push_back(8'd31);
    @(negedge clk);
    tx_wr = 1'b0;
    chk("latency_load_lo", {31'd0, spi_load}, 32'd0);
    @(negedge clk);
    chk("latency_load_hi", {31'd0, spi_load}, 32'd1);
    wait_idle();
    chk("spi_data_held", {24'd0, spi_data}, 32'd31);
    chk("rx_a5", {24'd0, rx_data}, 32'hA5);
    drain();

    // back-to-back pushes
    foreach (exp_tx[i]) exp_tx.delete();
    for (int i = 0; i < 3; i++) begin
      logic [7:0] bb [3];
      bb[0] = 8'd31; bb[1] = 8'h5C; bb[2] = 8'hFF;
      @(negedge clk);
      tx_wr = 1'b1; tx_data = bb[i]; exp_tx.push_back(bb[i]);
    end
    @(negedge clk);
    tx_wr = 1'b0;
    wait_idle();
    drain();

    // TX full with spi_norm stalled busy
    stall = 1'b1;
    base = xfers;
    for (int i = 0; i < 9; i++) begin
      push1(8'($urandom));
      chk("tx_full_fill", {31'd0, tx_full}, {31'd0, exp_tx.size() == DEPTH});
    end
    @(negedge clk);
    stall = 1'b0;
    wait_idle();
    chk("xfers_after_full", xfers - base, 32'd8);
    drain();

    // RX overflow
    for (int i = 0; i < 9; i++) begin
      push1(8'($urandom));
      wait_idle();
      if (i == 7) chk("rx_ovf_at_8", {31'd0, rx_ovf}, 32'd0);
    end
    chk("rx_ovf_at_9", {31'd0, rx_ovf}, {31'd0, exp_ovf});
    pulse_clr();
    exp_ovf = 1'b0;
    chk("rx_ovf_clr", {31'd0, rx_ovf}, 32'd0);
    drain();

    // start timeout: spi_norm never answers
    mute = 1'b1;
    push1(8'h77);
    wait_load();
    cnt = 0;
    while (spi_load && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("load_cycles", cnt, 32'd15);
    chk("start_err_set", {31'd0, start_err}, 32'd1);
    chk("timeout_idle", {31'd0, active}, 32'd0);
    chk("timeout_no_rx", {31'd0, rx_empty}, 32'd1);
    mute = 1'b0;
    push1(8'h42);
    wait_idle();
    chk("start_err_sticky", {31'd0, start_err}, 32'd1);
    pulse_clr();
    chk("start_err_clr", {31'd0, start_err}, 32'd0);
    drain();

    // randomized bursts
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        @(negedge clk);
        tx_wr = 1'b1; tx_data = b; exp_tx.push_back(b);
      end
      @(negedge clk);
      tx_wr = 1'b0;
      wait_idle();
      chk("rand_rx_empty", {31'd0, rx_empty}, {31'd0, exp_rx.size() == 0});
      if (exp_rx.size() >= 4) drain();
    end
    drain();
    chk("final_ovf", {31'd0, rx_ovf}, 32'd0);
    chk("final_tx_model_empty", exp_tx.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
